// File: rtl/sb_issue_commit_ctrl.sv
// Scoreboard issue/commit bookkeeping.
// Allocates trans_ids in program order, records writeback completion and
// exception flags per entry, retires the oldest entry once it is finished,
// and publishes which architectural registers have a pending writer.
module sb_issue_commit_ctrl #(
  parameter int unsigned NR_SB_ENTRIES = 4,
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES),
  parameter int unsigned NR_WB_PORTS   = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  logic                                 issue_valid_i,
  output logic                                 issue_ready_o,
  input  logic [4:0]                           issue_rd_i,
  output logic [TRANS_ID_BITS-1:0]             issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]               wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0]               wb_ex_valid_i,
  output logic                                 commit_valid_o,
  input  logic                                 commit_ack_i,
  output logic [TRANS_ID_BITS-1:0]             commit_trans_id_o,
  output logic [4:0]                           commit_rd_o,
  output logic                                 commit_ex_o,
  output logic [31:0]                          rd_busy_o,
  output logic [TRANS_ID_BITS:0]               count_o
);

  localparam logic [TRANS_ID_BITS:0]   FULL_CNT = (TRANS_ID_BITS+1)'(NR_SB_ENTRIES);
  localparam logic [TRANS_ID_BITS:0]   CNT_ONE  = (TRANS_ID_BITS+1)'(1);
  localparam logic [TRANS_ID_BITS-1:0] PTR_ONE  = TRANS_ID_BITS'(1);

  logic [NR_SB_ENTRIES-1:0] busy_q, busy_d;
  logic [NR_SB_ENTRIES-1:0] done_q, done_d;
  logic [NR_SB_ENTRIES-1:0] ex_q, ex_d;
  logic [4:0]               rd_q [NR_SB_ENTRIES];
  logic [4:0]               rd_d [NR_SB_ENTRIES];
  logic [TRANS_ID_BITS-1:0] issue_ptr_q, issue_ptr_d;
  logic [TRANS_ID_BITS-1:0] commit_ptr_q, commit_ptr_d;
  logic [TRANS_ID_BITS:0]   cnt_q, cnt_d;

  logic                     issue_fire_s;
  logic                     commit_fire_s;
  logic [31:0]              rd_busy_s;
  logic [TRANS_ID_BITS-1:0] wb_id_s [NR_WB_PORTS];

  for (genvar k = 0; k < NR_WB_PORTS; k++) begin : g_wb_id
    assign wb_id_s[k] = wb_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS];
  end

  // Handshakes only depend on registered state and flush, never on commit_ack_i
  assign issue_ready_o  = !flush_i && (cnt_q < FULL_CNT);
  assign commit_valid_o = !flush_i && busy_q[commit_ptr_q] && done_q[commit_ptr_q];
  assign issue_fire_s   = issue_valid_i && issue_ready_o;
  assign commit_fire_s  = commit_valid_o && commit_ack_i;

  assign issue_trans_id_o  = issue_ptr_q;
  assign commit_trans_id_o = commit_ptr_q;
  assign commit_rd_o       = rd_q[commit_ptr_q];
  assign commit_ex_o       = ex_q[commit_ptr_q];
  assign rd_busy_o         = rd_busy_s;
  assign count_o           = cnt_q;

  // Pending-writer mask: one bit per destination of every busy entry; x0 never busy
  always_comb begin
    rd_busy_s = 32'd0;
    for (int i = 0; i < NR_SB_ENTRIES; i++) begin
      rd_busy_s = rd_busy_s | ({32{busy_q[i]}} & (32'd1 << rd_q[i]));
    end
    rd_busy_s[0] = 1'b0;
  end

  // Next-state: flush clears everything; otherwise writeback, then commit, then issue
  always_comb begin
    busy_d       = busy_q;
    done_d       = done_q;
    ex_d         = ex_q;
    rd_d         = rd_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    cnt_d        = cnt_q;
    if (flush_i) begin
      busy_d       = '0;
      done_d       = '0;
      ex_d         = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      cnt_d        = '0;
      for (int i = 0; i < NR_SB_ENTRIES; i++) begin
        rd_d[i] = 5'd0;
      end
    end else begin
      // Writebacks only land on busy entries; several ports may hit the same id
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        done_d[wb_id_s[k]] = done_d[wb_id_s[k]] | (wb_valid_i[k] & busy_q[wb_id_s[k]]);
        ex_d[wb_id_s[k]]   = ex_d[wb_id_s[k]]
                             | (wb_valid_i[k] & busy_q[wb_id_s[k]] & wb_ex_valid_i[k]);
      end
      if (commit_fire_s) begin
        busy_d[commit_ptr_q] = 1'b0;
        commit_ptr_d         = commit_ptr_q + PTR_ONE;
      end else begin
        commit_ptr_d = commit_ptr_q;
      end
      // The issue slot is never busy (count < depth), so it cannot collide with writeback
      if (issue_fire_s) begin
        busy_d[issue_ptr_q] = 1'b1;
        done_d[issue_ptr_q] = 1'b0;
        ex_d[issue_ptr_q]   = 1'b0;
        rd_d[issue_ptr_q]   = issue_rd_i;
        issue_ptr_d         = issue_ptr_q + PTR_ONE;
      end else begin
        issue_ptr_d = issue_ptr_q;
      end
      case ({issue_fire_s, commit_fire_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= '0;
      done_q       <= '0;
      ex_q         <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < NR_SB_ENTRIES; i++) begin
        rd_q[i] <= 5'd0;
      end
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      ex_q         <= ex_d;
      rd_q         <= rd_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sb_issue_commit_ctrl.sv
// Bench for sb_issue_commit_ctrl: directed scenarios followed by random
// traffic, all checked against an in-order queue model of the scoreboard.
module tb_sb_issue_commit_ctrl;

  localparam int N   = 4;
  localparam int TIB = 2;
  localparam int NWB = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic             issue_valid_i = 1'b0;
  logic             issue_ready_o;
  logic [4:0]       issue_rd_i = 5'd0;
  logic [TIB-1:0]   issue_trans_id_o;
  logic [NWB-1:0]   wb_valid_i = '0;
  logic [NWB*TIB-1:0] wb_trans_id_i = '0;
  logic [NWB-1:0]   wb_ex_valid_i = '0;
  logic             commit_valid_o;
  logic             commit_ack_i = 1'b0;
  logic [TIB-1:0]   commit_trans_id_o;
  logic [4:0]       commit_rd_o;
  logic             commit_ex_o;
  logic [31:0]      rd_busy_o;
  logic [TIB:0]     count_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int       id;
    logic [4:0] rd;
    bit       done;
    bit       ex;
  } ent_t;

  ent_t mq[$];
  int   next_id = 0;

  sb_issue_commit_ctrl #(.NR_SB_ENTRIES(N), .TRANS_ID_BITS(TIB), .NR_WB_PORTS(NWB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rd_i(issue_rd_i), .issue_trans_id_o(issue_trans_id_o),
    .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i), .wb_ex_valid_i(wb_ex_valid_i),
    .commit_valid_o(commit_valid_o), .commit_ack_i(commit_ack_i),
    .commit_trans_id_o(commit_trans_id_o), .commit_rd_o(commit_rd_o),
    .commit_ex_o(commit_ex_o), .rd_busy_o(rd_busy_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model given the inputs currently driven
  task automatic check_all();
    logic        e_ready, e_cv;
    logic [31:0] e_busy;
    e_ready = !flush_i && (mq.size() < N);
    e_cv    = !flush_i && (mq.size() > 0) && mq[0].done;
    e_busy  = 32'd0;
    foreach (mq[j]) e_busy[mq[j].rd] = 1'b1;
    e_busy[0] = 1'b0;
    chk("issue_ready", {31'd0, issue_ready_o}, {31'd0, e_ready});
    chk("issue_trans_id", {30'd0, issue_trans_id_o}, next_id);
    chk("commit_valid", {31'd0, commit_valid_o}, {31'd0, e_cv});
    chk("rd_busy", rd_busy_o, e_busy);
    chk("count", {29'd0, count_o}, mq.size());
    if (e_cv) begin
      chk("commit_trans_id", {30'd0, commit_trans_id_o}, mq[0].id);
      chk("commit_rd", {27'd0, commit_rd_o}, {27'd0, mq[0].rd});
      chk("commit_ex", {31'd0, commit_ex_o}, {31'd0, mq[0].ex});
    end
  endtask

  // Advance the model across one clock edge using the driven inputs
  task automatic model_update();
    bit   fire_i, fire_c;
    ent_t e;
    fire_i = !flush_i && (mq.size() < N) && issue_valid_i;
    fire_c = !flush_i && (mq.size() > 0) && mq[0].done && commit_ack_i;
    if (flush_i) begin
      mq.delete();
      next_id = 0;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid_i[k]) begin
          foreach (mq[j]) begin
            if (mq[j].id == int'(wb_trans_id_i[k*TIB +: TIB])) begin
              mq[j].done = 1'b1;
              mq[j].ex   = mq[j].ex | wb_ex_valid_i[k];
            end
          end
        end
      end
      if (fire_c) void'(mq.pop_front());
      if (fire_i) begin
        e.id = next_id; e.rd = issue_rd_i; e.done = 1'b0; e.ex = 1'b0;
        mq.push_back(e);
        next_id = (next_id + 1) % N;
      end
    end
  endtask

  task automatic step(input logic fl, input logic iv, input logic [4:0] rd,
                      input logic [3:0] wv, input logic [7:0] wid, input logic [3:0] wex,
                      input logic ack);
    @(negedge clk_i);
    flush_i = fl; issue_valid_i = iv; issue_rd_i = rd;
    wb_valid_i = wv; wb_trans_id_i = wid; wb_ex_valid_i = wex; commit_ack_i = ack;
    #1;
    check_all();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("rst_cv", {31'd0, commit_valid_o}, 32'd0);
    chk("rst_ctid", {30'd0, commit_trans_id_o}, 32'd0);
    chk("rst_crd", {27'd0, commit_rd_o}, 32'd0);
    chk("rst_cex", {31'd0, commit_ex_o}, 32'd0);
    chk("rst_busy", rd_busy_o, 32'd0);
    chk("rst_count", {29'd0, count_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill with rd 1..4
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 5'(i), 4'd0, 8'd0, 4'd0, 1'b0);
    chk("full_ready", {31'd0, issue_ready_o}, 32'd0);
    chk("full_count", {29'd0, count_o}, 32'd4);
    chk("full_busy", rd_busy_o, 32'h0000_001E);

    // Out-of-order writeback to ids 2 and 0 on ports 0 and 1
    step(1'b0, 1'b0, 5'd0, 4'b0011, 8'b00_00_00_10, 4'd0, 1'b0);
    chk("ooo_cv", {31'd0, commit_valid_o}, 32'd1);
    chk("ooo_id", {30'd0, commit_trans_id_o}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b1);
    chk("wait_id1_cv", {31'd0, commit_valid_o}, 32'd0);
    step(1'b0, 1'b0, 5'd0, 4'b0100, 8'b00_01_00_00, 4'd0, 1'b0);
    chk("id1_cv", {31'd0, commit_valid_o}, 32'd1);
    chk("id1_id", {30'd0, commit_trans_id_o}, 32'd1);
    step(1'b0, 1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b1);
    chk("b2b_cv", {31'd0, commit_valid_o}, 32'd1);
    chk("b2b_id", {30'd0, commit_trans_id_o}, 32'd2);
    step(1'b0, 1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b1);

    // Refill, then writeback id 3 on port 0 (ex) and port 3 (no ex)
    for (int i = 5; i <= 7; i++) step(1'b0, 1'b1, 5'(i), 4'd0, 8'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 4'b1001, 8'b11_00_00_11, 4'b0001, 1'b0);
    chk("ex_cv", {31'd0, commit_valid_o}, 32'd1);
    chk("ex_id", {30'd0, commit_trans_id_o}, 32'd3);
    chk("ex_flag", {31'd0, commit_ex_o}, 32'd1);
    // Full: issue and commit in the same cycle, issue refused
    step(1'b0, 1'b1, 5'd8, 4'd0, 8'd0, 4'd0, 1'b1);
    chk("full_commit_count", {29'd0, count_o}, 32'd3);
    chk("full_commit_ready", {31'd0, issue_ready_o}, 32'd1);
    step(1'b0, 1'b1, 5'd9, 4'd0, 8'd0, 4'd0, 1'b0);
    chk("refill_count", {29'd0, count_o}, 32'd4);

    // Retire id 0, then writeback to the now non-busy id 0
    step(1'b0, 1'b0, 5'd0, 4'b0001, 8'b00_00_00_00, 4'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 4'd0, 8'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 4'b0001, 8'b00_00_00_00, 4'b0001, 1'b0);
    chk("stale_wb_cv", {31'd0, commit_valid_o}, 32'd0);
    chk("stale_wb_count", {29'd0, count_o}, 32'd3);

    // Three busy, flush with simultaneous issue, writeback and ack
    step(1'b0, 1'b0, 5'd0, 4'b0001, 8'b00_00_00_01, 4'd0, 1'b0);
    step(1'b1, 1'b1, 5'd12, 4'b0001, 8'b00_00_00_10, 4'd0, 1'b1);
    idle();
    chk("flush_count", {29'd0, count_o}, 32'd0);
    chk("flush_busy", rd_busy_o, 32'd0);
    chk("flush_id", {30'd0, issue_trans_id_o}, 32'd0);
    chk("flush_cv", {31'd0, commit_valid_o}, 32'd0);

    // Reset mid-stream with two busy, one done
    step(1'b0, 1'b1, 5'd10, 4'd0, 8'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 5'd11, 4'd0, 8'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 4'b0001, 8'b00_00_00_00, 4'd0, 1'b0);
    @(negedge clk_i);
    wb_valid_i = '0; issue_valid_i = 1'b0; commit_ack_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_ready", {31'd0, issue_ready_o}, 32'd1);
    chk("mrst_cv", {31'd0, commit_valid_o}, 32'd0);
    chk("mrst_busy", rd_busy_o, 32'd0);
    chk("mrst_count", {29'd0, count_o}, 32'd0);
    chk("mrst_id", {30'd0, issue_trans_id_o}, 32'd0);
    mq.delete();
    next_id = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, 1'b1, 5'd13, 4'd0, 8'd0, 4'd0, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 31)),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           8'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
